// File: rtl/ysyx_22041412_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter sharing one variable-latency memory port.
// One transaction in flight, round-robin on ties, response watchdog with sticky err.
module ysyx_22041412_mem_arbiter #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  localparam logic OwnIfu = 1'b0;
  localparam logic OwnLsu = 1'b1;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MaskW-1:0]  wmask_q, wmask_d;

  logic              grant_ifu, grant_lsu;
  logic              expire;
  logic              resp_fire;
  logic [DATA_W-1:0] resp_data;

  // Round-robin grant: a lone requester always wins, a tie goes to whoever was not served last.
  always_comb begin
    grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_q == OwnLsu));
    grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_q == OwnIfu));
  end

  // State, ownership, watchdog and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnIfu;
      last_q  <= OwnLsu;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // Next-state logic and all handshake/data outputs.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    mem_req_valid  = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    expire         = 1'b0;
    resp_fire      = 1'b0;
    resp_data      = '0;

    case (state_q)
      StIdle: begin
        // Readys are masked while rst is held so nothing looks accepted during reset.
        ifu_req_ready = grant_ifu && !rst;
        lsu_req_ready = grant_lsu && !rst;
        if (grant_ifu) begin
          addr_d  = ifu_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          owner_d = OwnIfu;
          last_d  = OwnIfu;
          state_d = StReq;
        end else if (grant_lsu) begin
          addr_d  = lsu_addr;
          we_d    = lsu_we;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          owner_d = OwnLsu;
          last_d  = OwnLsu;
          state_d = StReq;
        end
      end

      StReq: begin
        mem_req_valid = 1'b1;
        mem_we        = we_q;
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
        if (mem_req_ready) begin
          state_d = StResp;
          cnt_d   = '0;
        end
      end

      StResp: begin
        // A real response in the expiry cycle takes priority over the watchdog.
        expire    = (TIMEOUT != 0) && !mem_resp_valid && (cnt_q == CntMax);
        resp_fire = mem_resp_valid || expire;
        resp_data = mem_resp_valid ? mem_rdata : '0;
        if (owner_q == OwnIfu) begin
          ifu_resp_valid = resp_fire;
          ifu_rdata      = resp_data;
        end else begin
          lsu_resp_valid = resp_fire;
          lsu_rdata      = resp_data;
        end
        if (mem_resp_valid) begin
          state_d = StIdle;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign err  = err_q;

endmodule

// File: tb/tb_ysyx_22041412_mem_arbiter.sv
// Self-checking bench: vector table plus hand sequences for watchdog and mid-flight reset.
module tb_ysyx_22041412_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        busy, err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic [63:0] ifu_a;
    logic [63:0] lsu_a;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          req_dly;
    int          resp_dly;
    logic        exp_lsu;
  } vec_t;

  typedef struct {
    logic        lsu;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb[$];

  ysyx_22041412_mem_arbiter #(
    .ADDR_W (64),
    .DATA_W (64),
    .TIMEOUT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_we        (lsu_we),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic iv, logic lv, logic [63:0] ia, logic [63:0] la, logic we,
                              logic [63:0] wd, logic [7:0] wm, logic [63:0] rd, int rq,
                              int rs, logic el);
    vec_t v;
    v.ifu_v = iv; v.lsu_v = lv; v.ifu_a = ia; v.lsu_a = la; v.we = we;
    v.wdata = wd; v.wmask = wm; v.rdata = rd; v.req_dly = rq; v.resp_dly = rs;
    v.exp_lsu = el;
    return v;
  endfunction

  // Response monitor: every resp pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!ifu_resp_valid) chk("ifu_rdata_gated", ifu_rdata, 64'h0);
    if (!lsu_resp_valid) chk("lsu_rdata_gated", lsu_rdata, 64'h0);
    if (ifu_resp_valid || lsu_resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {62'h0, ifu_resp_valid, lsu_resp_valid}, 64'h0);
      end else begin
        e = sb.pop_front();
        chk("resp_both", {63'h0, ifu_resp_valid & lsu_resp_valid}, 64'h0);
        chk("resp_owner", {63'h0, lsu_resp_valid}, {63'h0, e.lsu});
        chk("resp_rdata", lsu_resp_valid ? lsu_rdata : ifu_rdata, e.rdata);
      end
    end
  end

  task automatic issue(input vec_t v, input bit push);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    ifu_req_valid  = v.ifu_v;
    ifu_addr       = v.ifu_a;
    lsu_req_valid  = v.lsu_v;
    lsu_addr       = v.lsu_a;
    lsu_we         = v.we;
    lsu_wdata      = v.wdata;
    lsu_wmask      = v.wmask;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(ifu_req_ready || lsu_req_ready) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("grant_ifu", {63'h0, ifu_req_ready}, {63'h0, !v.exp_lsu});
    chk("grant_lsu", {63'h0, lsu_req_ready}, {63'h0, v.exp_lsu});
    if (push) begin
      e.lsu   = v.exp_lsu;
      e.rdata = v.rdata;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
  endtask

  // Hold mem_req_ready low for req_dly cycles; payload must stay put throughout.
  task automatic req_phase(input vec_t v);
    for (int d = 0; d <= v.req_dly; d++) begin
      mem_req_ready = (d == v.req_dly);
      @(negedge clk);
      chk("mem_req_valid", {63'h0, mem_req_valid}, 64'h1);
      chk("mem_addr", mem_addr, v.exp_lsu ? v.lsu_a : v.ifu_a);
      chk("mem_we", {63'h0, mem_we}, {63'h0, v.exp_lsu & v.we});
      chk("mem_wdata", mem_wdata, v.exp_lsu ? v.wdata : 64'h0);
      chk("mem_wmask", {56'h0, mem_wmask}, {56'h0, v.exp_lsu ? v.wmask : 8'h0});
      chk("ready_in_req", {62'h0, ifu_req_ready, lsu_req_ready}, 64'h0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic resp_phase(input vec_t v);
    for (int d = 0; d <= v.resp_dly; d++) begin
      mem_resp_valid = (d == v.resp_dly);
      mem_rdata      = (d == v.resp_dly) ? v.rdata : 64'hA5A5_0000_0000_5A5A;
      @(negedge clk);
      chk("mem_idle_in_resp", {63'h0, mem_req_valid}, 64'h0);
      chk("mem_addr_zero", mem_addr, 64'h0);
      #1;
      if (d == v.resp_dly) chk("resp_consumed", sb.size(), 0);
      else chk("resp_waiting", sb.size(), 1);
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_rdata      = 64'h0;
    @(negedge clk);
    chk("busy_after", {63'h0, busy}, 64'h0);
    chk("err_after", {63'h0, err}, 64'h0);
    sb.delete();
  endtask

  task automatic run_txn(input vec_t v);
    issue(v, 1'b1);
    req_phase(v);
    resp_phase(v);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[9];
    vec_t tv;

    vecs[0] = mk(1, 1, 64'h8000_0000, 64'h8000_0100, 1, 64'h1111, 8'hFF, 64'h13, 0, 0, 0);
    vecs[1] = mk(1, 1, 64'h8000_0004, 64'h8000_0108, 0, 64'h0, 8'h00,
                 64'hCAFE_F00D_1234_5678, 0, 0, 1);
    vecs[2] = mk(1, 1, 64'h8000_0008, 64'h8000_0110, 1, 64'h2222, 8'h03, 64'h0010_0093, 1, 0, 0);
    vecs[3] = mk(1, 1, 64'h8000_000C, 64'h8000_0118, 1, 64'h3333, 8'hF0, 64'h0, 0, 1, 1);
    vecs[4] = mk(1, 0, 64'h8000_0000, 64'h0, 0, 64'h0, 8'h00, 64'h13, 0, 0, 0);
    vecs[5] = mk(0, 1, 64'h0, 64'h8000_1000, 1, 64'hDEAD_BEEF, 8'h0F, 64'h0, 3, 0, 1);
    vecs[6] = mk(0, 1, 64'h0, 64'h8000_1008, 0, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0, 2, 1);
    // Response lands in the very cycle the watchdog would expire: must be a normal completion.
    vecs[7] = mk(1, 0, 64'h8000_0010, 64'h0, 0, 64'h0, 8'h00, 64'h73, 0, 3, 0);
    vecs[8] = mk(0, 1, 64'h0, 64'h8000_2000, 0, 64'h0, 8'h00, 64'h7777_8888, 2, 2, 1);

    rst            = 1'b1;
    ifu_req_valid  = 1'b1;
    lsu_req_valid  = 1'b1;
    ifu_addr       = 64'h0;
    lsu_addr       = 64'h0;
    lsu_we         = 1'b0;
    lsu_wdata      = 64'h0;
    lsu_wmask      = 8'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 64'h0;

    repeat (2) @(negedge clk);
    chk("rst_ready", {62'h0, ifu_req_ready, lsu_req_ready}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_err", {63'h0, err}, 64'h0);
    chk("rst_mem_req", {63'h0, mem_req_valid}, 64'h0);
    @(posedge clk); #1;
    rst           = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Watchdog: no response ever; owner pulses with rdata=0 in the fourth RESP cycle.
    tv = mk(1, 0, 64'h8000_3000, 64'h0, 0, 64'h0, 8'h00, 64'h0, 0, 0, 0);
    issue(tv, 1'b1);
    req_phase(tv);
    mem_rdata = 64'hAAAA_5555_AAAA_5555;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      if (k < 4) chk("wd_pending", sb.size(), 1);
      else chk("wd_fired", sb.size(), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("wd_err", {63'h0, err}, 64'h1);
    chk("wd_busy", {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    chk("late_resp_busy", {63'h0, busy}, 64'h0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_rdata      = 64'h0;
    sb.delete();

    // Reset while in RESP: transaction dropped without a pulse, err cleared.
    tv = mk(1, 0, 64'h8000_4000, 64'h0, 0, 64'h0, 8'h00, 64'h0, 0, 0, 0);
    issue(tv, 1'b0);
    req_phase(tv);
    @(negedge clk);
    chk("mid_busy", {63'h0, busy}, 64'h1);
    @(posedge clk); #1;
    rst            = 1'b1;
    ifu_req_valid  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h1234;
    @(negedge clk);
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    chk("mid_rst_err", {63'h0, err}, 64'h0);
    chk("mid_rst_ready", {63'h0, ifu_req_ready}, 64'h0);
    @(posedge clk); #1;
    rst            = 1'b0;
    ifu_req_valid  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 64'h0;

    run_txn(mk(1, 0, 64'h8000_5000, 64'h0, 0, 64'h0, 8'h00, 64'h0000_0297, 0, 0, 0));

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_mem_arbiter.md
Name: ysyx_22041412_mem_arbiter

Overview:
- Two-requester arbiter that shares the single data SRAM port between instruction fetch (IFU) and load/store (LSU).
- Replaces the separate fetch memory and data SRAM ports in the multicycle RV64 core with one memory port that has variable latency.
- Each port handshakes with valid/ready. One transaction is outstanding at a time. Simultaneous requests are arbitrated round-robin. A response timeout watchdog is included.

Parameters:
- ADDR_W, 64, address width of all ports.
- DATA_W, 64, data width. Write mask width is DATA_W/8.
- TIMEOUT, 255, maximum cycles spent in RESP before the watchdog fires. 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address (current PC).
- ifu_resp_valid  out  1  fetch data valid, one-cycle pulse.
- ifu_rdata  out  DATA_W  fetch data.
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  load/store request accepted this cycle.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_addr  in  ADDR_W  data address (ALU result).
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  store byte enables.
- lsu_resp_valid  out  1  load data returned, or store completed; one-cycle pulse.
- lsu_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  request to SRAM.
- mem_req_ready  in  1  SRAM accepted the request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_wmask  out  DATA_W/8  byte enables.
- mem_resp_valid  in  1  SRAM response.
- mem_rdata  in  DATA_W  SRAM read data.
- busy  out  1  state is not IDLE.
- err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, REQ, RESP. Reset: state=IDLE, owner=IFU, last_served=LSU (IFU wins the first tie), err=0, timeout counter=0, latched payload=0. All valid/ready outputs are 0 during and after reset.
- Grant, IDLE only:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_served.
  - The granted port's req_ready is a combinational 1 in IDLE. The other port's ready is 0. Both readys are 0 in REQ and RESP.
- Accept (valid && ready in IDLE):
  - Latch addr, we, wdata, and wmask into payload registers. IFU requests force we=0 and wmask=0.
  - Set owner and last_served to the granted port. Go to REQ next cycle.
- REQ:
  - mem_req_valid=1 with the latched payload, held stable until mem_req_ready=1.
  - On mem_req_ready: go to RESP and clear the counter.
  - mem_req_valid=0 in every other state, and mem_* payload outputs=0 outside REQ.
- RESP:
  - The owner's resp_valid = mem_resp_valid, combinational. The owner's rdata = mem_rdata.
  - On mem_resp_valid: go to IDLE.
  - The non-owner's resp_valid=0. Both rdata outputs are 0 when their resp_valid=0.
- mem_resp_valid in IDLE or REQ is ignored.
- Minimum latency from accept cycle N:
  - mem_req_valid is seen in N+1.
  - The response can return at earliest in N+2.
  - The next accept can occur at earliest in N+3.
- Watchdog, TIMEOUT>0:
  - The counter increments every RESP cycle without mem_resp_valid.
  - When counter == TIMEOUT-1 and no response arrives: pulse the owner's resp_valid with rdata=0, set err=1, go to IDLE.
  - A late mem_resp_valid after this is ignored.
  - A response that arrives in the same cycle as expiry is a normal response; err stays 0.
- err stays set until rst.
- Requester valid dropped before accept: no transaction occurs. Once accepted, the transaction completes regardless of requester inputs.
- rst asserted mid-transaction: immediately return to IDLE and drop the in-flight transaction. No resp pulse is generated.

Test Plan:
- IFU alone, addr=0x80000000, mem ready same cycle, resp after 1 cycle with rdata=0x00000013 → ifu_req_ready in cycle 0, mem_req_valid with addr 0x80000000 and we=0 in cycle 1, ifu_resp_valid with rdata 0x13 in cycle 2, busy low in cycle 3.
- IFU and LSU both valid out of reset, repeated 4 times → grants alternate IFU, LSU, IFU, LSU. lsu_resp_valid never pulses during an IFU transaction, and vice versa.
- LSU store, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready held low for 3 cycles → mem_req_valid and payload stable for 4 cycles. lsu_resp_valid follows the response, with lsu_rdata=0 permitted.
- TIMEOUT=4, mem_resp_valid never asserted → ifu_resp_valid pulses with rdata=0 after 4 RESP cycles, err=1. A later mem_resp_valid produces no pulse.
- rst pulsed while in RESP → busy=0, err=0, no resp pulse. The next IFU request is serviced normally.
